// File: rtl/set_assoc_btb.sv
// Set-associative branch target buffer: combinational lookup, updates land on the next clk edge.
// A flush starts a one-set-per-cycle invalidation sweep; lookups miss and updates drop while busy.
package set_assoc_btb_pkg;
    typedef enum logic [1:0] {ET_INVALID = 2'd0, ET_BRANCH = 2'd1, ET_JUMP = 2'd2, ET_RET = 2'd3} entry_type_t;
    typedef enum logic [1:0] {CF_NONE = 2'd0, CF_BRANCH = 2'd1, CF_JAL = 2'd2, CF_JALR = 2'd3} cflow_mode_t;
    typedef enum logic [1:0] {HINT_NONE = 2'd0, HINT_CALL = 2'd1, HINT_RET = 2'd2} cflow_hint_t;
endpackage

module set_assoc_btb
    import set_assoc_btb_pkg::*;
#(
    parameter int NUM_SETS = 64,
    parameter int NUM_WAYS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    output logic        busy,
    input  logic [31:0] pc_f,
    input  logic        ras_empty,
    input  logic [31:0] ras_pop_addr,
    output logic        btb_hit,
    output entry_type_t pred_type,
    output logic [31:0] pred_target,
    input  logic [31:0] pc_e,
    input  cflow_mode_t cflow_mode,
    input  cflow_hint_t cflow_hint,
    input  logic        cflow_taken,
    input  logic [31:0] cflow_target
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 30 - IDX_W;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [WAY_W-1:0]    rr_q    [NUM_SETS];
    entry_type_t         type_q  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [31:0]         tgt_q   [NUM_SETS][NUM_WAYS];

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [3:0]       f_nmatch;
    logic [WAY_W-1:0] f_way;

    always_comb begin
        f_idx    = pc_f[2 +: IDX_W];
        f_tag    = pc_f[31 -: TAG_W];
        f_nmatch = '0;
        f_way    = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[f_idx][w] && tag_q[f_idx][w] == f_tag) begin
                f_nmatch = f_nmatch + 4'd1;
                f_way    = WAY_W'(w);
            end
        end
        // Multiple matching ways are treated as a miss rather than picking one arbitrarily.
        btb_hit     = !busy && (f_nmatch == 4'd1);
        pred_type   = ET_INVALID;
        pred_target = '0;
        if (btb_hit) begin
            pred_type   = type_q[f_idx][f_way];
            pred_target = (pred_type == ET_RET && !ras_empty) ? ras_pop_addr : tgt_q[f_idx][f_way];
        end
    end

    // ---------------- update ----------------
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_en, u_hit, u_inv;
    logic [WAY_W-1:0] u_hit_way, u_inv_way, u_way, u_rr_nxt;
    entry_type_t      u_type;

    always_comb begin
        u_idx     = pc_e[2 +: IDX_W];
        u_tag     = pc_e[31 -: TAG_W];
        u_en      = (cflow_mode != CF_NONE) && cflow_taken && (state_q == S_IDLE) && !flush;
        u_type    = (cflow_mode == CF_BRANCH) ? ET_BRANCH :
                    (cflow_hint == HINT_RET)  ? ET_RET : ET_JUMP;
        u_hit     = 1'b0;
        u_inv     = 1'b0;
        u_hit_way = '0;
        u_inv_way = '0;
        // Descending scan so the lowest-numbered candidate is the last one written.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
                u_hit     = 1'b1;
                u_hit_way = WAY_W'(w);
            end
            if (!valid_q[u_idx][w]) begin
                u_inv     = 1'b1;
                u_inv_way = WAY_W'(w);
            end
        end
        u_way    = u_hit ? u_hit_way : (u_inv ? u_inv_way : rr_q[u_idx]);
        u_rr_nxt = (rr_q[u_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[u_idx] + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (state_q == S_SWEEP) begin
            valid_q[cnt_q] <= '0;
            rr_q[cnt_q]    <= '0;
        end else if (u_en) begin
            valid_q[u_idx][u_way] <= 1'b1;
            if (!u_hit && !u_inv) rr_q[u_idx] <= u_rr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (u_en) begin
            type_q[u_idx][u_way] <= u_type;
            tag_q[u_idx][u_way]  <= u_tag;
            tgt_q[u_idx][u_way]  <= cflow_target;
        end
    end

    // ---------------- flush sweep FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_SWEEP;
                    cnt_d   = '0;
                end
            end
            S_SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(NUM_SETS - 1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_SWEEP);
    end
endmodule

// File: doc/set_assoc_btb.md
SET_ASSOC_BTB -- requirements
Module: set_assoc_btb

Interface
REQ-001 The block SHALL have parameter NUM_SETS, default 64, meaning the number of sets; it SHALL be a power of two, at least 2.
REQ-002 The block SHALL have parameter NUM_WAYS, default 2, meaning the associativity; it SHALL be a power of two from 1 to 8.
REQ-003 The block SHALL derive IDX_W = log2(NUM_SETS) and TAG_W = 30 - IDX_W; the index SHALL be pc[2 +: IDX_W] and the tag SHALL be pc[31 -: TAG_W].
REQ-004 The block SHALL have these ports:
  clk  in  1  clock
  rst_n  in  1  reset; one clock, asynchronous, active-low
  flush  in  1  pulse that invalidates all entries
  busy  out  1  invalidation sweep in progress
  pc_f  in  32  fetch PC for prediction
  ras_empty  in  1  return stack empty
  ras_pop_addr  in  32  return stack top
  btb_hit  out  1  prediction valid
  pred_type  out  entry_type_t  type of the hitting entry
  pred_target  out  32  predicted target
  pc_e  in  32  execute-stage PC for update
  cflow_mode  in  cflow_mode_t  resolved control-flow class
  cflow_hint  in  cflow_hint_t  call/return hint
  cflow_taken  in  1  resolved taken
  cflow_target  in  32  resolved target

Function
REQ-005 Each way of each set SHALL hold valid (flop), type, tag and target.
REQ-006 Prediction SHALL be combinational from pc_f; btb_hit SHALL be 1 iff busy=0 and exactly one valid way of set idx(pc_f) has a tag match.
REQ-007 On a hit, pred_type and pred_target SHALL come from the matching way; otherwise they SHALL be the invalid type and 0.
REQ-008 For a RET-type hit, pred_target SHALL be ras_pop_addr when ras_empty=0, and the stored target otherwise.
REQ-009 An update SHALL occur when cflow_mode is BRANCH, JAL or JALR, cflow_taken=1 and busy=0.
REQ-010 The stored type SHALL be BRANCH for BRANCH, RET for JAL/JALR with hint RET, and JUMP otherwise.
REQ-011 If the update tag matches a valid way in set idx(pc_e), that way SHALL be overwritten and the replacement pointer SHALL be left unchanged.
REQ-012 On an update miss, the lowest-numbered invalid way SHALL be allocated; if all ways are valid, the way at the set's round-robin pointer SHALL be allocated and the pointer SHALL be incremented modulo NUM_WAYS.
REQ-013 The write SHALL take effect at the next clk edge; a lookup in the same cycle to the same set SHALL return the pre-write contents, with no forwarding.
REQ-014 A not-taken resolution SHALL NOT modify any state.
REQ-015 The FSM SHALL have states IDLE and SWEEP and a counter of IDX_W bits.
REQ-016 In IDLE, flush=1 SHALL move the FSM to SWEEP with the counter at 0.
REQ-017 In SWEEP, each cycle SHALL clear the valid bits of all ways and the round-robin pointer of set[counter], then increment the counter.
REQ-018 The SWEEP state SHALL last exactly NUM_SETS cycles, ending in IDLE after the set NUM_SETS-1 is cleared.
REQ-019 busy SHALL be 1 whenever the FSM is in SWEEP.
REQ-020 flush asserted during SWEEP SHALL be ignored and SHALL NOT restart the counter.
REQ-021 If flush and a qualifying update arrive in the same cycle in IDLE, flush SHALL win and the update SHALL be dropped.
REQ-022 Updates arriving while busy=1 SHALL be dropped.

Reset
REQ-023 Asserting rst_n low SHALL asynchronously force all valid bits to 0, all round-robin pointers to 0, the FSM to IDLE and the counter to 0.
REQ-024 While in reset, outputs SHALL be btb_hit=0, busy=0, pred_type=invalid and pred_target=0.
REQ-025 Reset asserted mid-sweep SHALL abort the sweep; after rst_n is released, the FSM SHALL be in IDLE.
REQ-026 Type, tag and target storage SHALL NOT require reset.

Verification
REQ-027 Basic hit/miss: update pc_e=0x100 as a taken JAL to 0x400 -> the next cycle, pc_f=0x100 gives btb_hit=1, type JUMP, target 0x400; pc_f=0x104 gives btb_hit=0.
REQ-028 Replacement (NUM_SETS=64, NUM_WAYS=2): taken branches at 0x100, 0x200 and 0x300, all in set 0 -> 0x100 is evicted, 0x200 and 0x300 hit; a further update at 0x400 evicts 0x200.
REQ-029 Return prediction: JALR with hint RET at 0x80 -> with ras_empty=0 and ras_pop_addr=0x1234, pred_target=0x1234; with ras_empty=1, pred_target equals the stored target.
REQ-030 Flush: fill 3 entries, then pulse flush -> busy=1 for exactly 64 cycles, updates during busy are dropped, and all lookups miss afterwards.
REQ-031 Simultaneous events: flush and a taken update in the same cycle -> the entry is absent after the sweep; a same-cycle lookup during an update to the same set returns the old data.
REQ-032 Reset mid-sweep: assert rst_n low at sweep cycle 10 -> busy=0 and btb_hit=0 immediately, and the FSM is in IDLE after release.
